// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: default widths, opcodes,
// FSM state encoding and the iterative-unit mode select.
package cpu_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned SEL_W_DEF = 4;
   localparam int unsigned OP_W      = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
   localparam logic [OP_W-1:0] OP_AND  = 3'd2;
   localparam logic [OP_W-1:0] OP_OR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
   localparam logic [OP_W-1:0] OP_MUL  = 3'd6;
   localparam logic [OP_W-1:0] OP_DIVU = 3'd7;

   // Mode select for the shared multiply/divide datapath
   localparam logic MD_MUL = 1'b0;
   localparam logic MD_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      WB   = 2'd2
   } state_t;

   // True for opcodes that run through the iterative unit
   function automatic logic is_iter_op(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter16.sv
// Shared iterative datapath: unsigned shift-add multiply (low WIDTH bits)
// and restoring divide (quotient), one bit per step, WIDTH steps.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   load          capture operands/mode, counter <= WIDTH-1
//   mode          MD_MUL or MD_DIV (sampled on load)
//   step          advance one iteration
//   a, b          operands (mul: a*b, div: a/b)
//   done_c        last iteration is being taken this cycle
//   result_c      value the accumulators hold after this step
module muldiv_iter16
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             mode,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] result_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   // acc: product (mul) / partial remainder (div)
   // sr:  multiplier shifting right (mul) / dividend->quotient shifting left (div)
   // opnd: multiplicand shifting left (mul) / divisor (div)
   logic [WIDTH-1:0] acc_q, sr_q, opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mode_q;

   logic [WIDTH-1:0] acc_n, sr_n, opnd_n, diff;
   logic [WIDTH:0]   rem_sh;
   logic             ge;

   // One iteration of the selected algorithm
   always_comb begin
      acc_n  = acc_q;
      sr_n   = sr_q;
      opnd_n = opnd_q;
      rem_sh = {acc_q, sr_q[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, opnd_q});
      // When ge holds the difference is below the divisor, so it fits WIDTH bits
      diff   = rem_sh[WIDTH-1:0] - opnd_q;
      if (mode_q == MD_MUL) begin
         acc_n  = acc_q + (sr_q[0] ? opnd_q : '0);
         sr_n   = sr_q >> 1;
         opnd_n = opnd_q << 1;
      end else begin
         // Zero divisor: ge is always true, so the quotient fills with ones
         acc_n = ge ? diff : rem_sh[WIDTH-1:0];
         sr_n  = {sr_q[WIDTH-2:0], ge};
      end
   end

   assign done_c   = step && (cnt_q == '0);
   assign result_c = (mode_q == MD_MUL) ? acc_n : sr_n;

   // Iteration registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         sr_q   <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         mode_q <= MD_MUL;
      end else if (load) begin
         acc_q  <= '0;
         sr_q   <= (mode == MD_MUL) ? b : a;
         opnd_q <= (mode == MD_MUL) ? a : b;
         cnt_q  <= CNT_W'(WIDTH - 1);
         mode_q <= mode;
      end else if (step) begin
         acc_q  <= acc_n;
         sr_q   <= sr_n;
         opnd_q <= opnd_n;
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/exec_unit16.sv
// Execute stage after the register file: one ALU op in flight, write-back
// triple (wb_data, wb_sel, wb_en) feeds the file's write port.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, op         issue request and opcode (sampled only when idle)
//   dst_sel           destination register
//   a, b              operands from register file ports A/B
//   busy              FSM not idle; backpressure to the issuer
//   wb_data, wb_sel   result and destination, held between write-backs
//   wb_en             one-cycle write pulse
//   flag_z, flag_c    zero and carry/borrow of the last write-back
module exec_unit16
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SEL_W = SEL_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [SEL_W-1:0] dst_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] wb_data,
   output logic [SEL_W-1:0] wb_sel,
   output logic             wb_en,
   output logic             flag_z,
   output logic             flag_c
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   state_t           state_q, state_n;
   logic [SEL_W-1:0] dst_q;

   logic             accept_c, md_load_c, md_step_c, md_done_c, wb_load_c;
   logic             md_mode_c;
   logic [WIDTH-1:0] md_result_c;
   logic [WIDTH:0]   add_c;
   logic [WIDTH-1:0] alu_res_c, res_c;
   logic             alu_cy_c, res_cy_c;
   logic [SEL_W-1:0] res_sel_c;

   // Single-cycle ALU on the operands presented at the accept edge; these are
   // the same values the iterative unit and dst_q capture on that edge
   always_comb begin
      add_c     = {1'b0, a} + {1'b0, b};
      alu_res_c = '0;
      alu_cy_c  = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_c = add_c[WIDTH-1:0];
            alu_cy_c  = add_c[WIDTH];
         end
         OP_SUB: begin
            alu_res_c = a - b;
            alu_cy_c  = (a < b);
         end
         OP_AND:  alu_res_c = a & b;
         OP_OR:   alu_res_c = a | b;
         OP_XOR:  alu_res_c = a ^ b;
         OP_SHL:  alu_res_c = a << b[SHAMT_W-1:0];
         default: alu_res_c = '0;
      endcase
   end

   assign md_mode_c = (op == OP_DIVU) ? MD_DIV : MD_MUL;
   assign md_step_c = (state_q == ITER);

   muldiv_iter16 #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (md_load_c),
      .mode     (md_mode_c),
      .step     (md_step_c),
      .a        (a),
      .b        (b),
      .done_c   (md_done_c),
      .result_c (md_result_c)
   );

   // Next-state and write-back selection
   always_comb begin
      state_n   = state_q;
      accept_c  = 1'b0;
      md_load_c = 1'b0;
      wb_load_c = 1'b0;
      res_c     = alu_res_c;
      res_cy_c  = alu_cy_c;
      res_sel_c = dst_sel;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               if (is_iter_op(op)) begin
                  md_load_c = 1'b1;
                  state_n   = ITER;
               end else begin
                  wb_load_c = 1'b1;
                  state_n   = WB;
               end
            end
         end
         ITER: begin
            if (md_done_c) begin
               wb_load_c = 1'b1;
               res_c     = md_result_c;
               res_cy_c  = 1'b0;
               res_sel_c = dst_q;
               state_n   = WB;
            end
         end
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_n;
   end

   // Registered outputs; write-back fields load on the edge entering WB
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dst_q   <= '0;
         busy    <= 1'b0;
         wb_en   <= 1'b0;
         wb_data <= '0;
         wb_sel  <= '0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
      end else begin
         busy  <= (state_n != IDLE);
         wb_en <= wb_load_c;
         if (accept_c) dst_q <= dst_sel;
         if (wb_load_c) begin
            wb_data <= res_c;
            wb_sel  <= res_sel_c;
            flag_z  <= (res_c == '0);
            flag_c  <= res_cy_c;
         end
      end
   end

endmodule

// File: tb/tb_exec_unit16.sv
// Bench for exec_unit16: scoreboard of expected write-backs plus per-scenario
// timing checks.
module tb_exec_unit16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [3:0]  dst_sel = 4'd0;
   logic [15:0] a = 16'd0;
   logic [15:0] b = 16'd0;
   logic        busy, wb_en, flag_z, flag_c;
   logic [15:0] wb_data;
   logic [3:0]  wb_sel;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  sel;
      logic        z;
      logic        c;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   exec_unit16 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .dst_sel (dst_sel),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .wb_data (wb_data),
      .wb_sel  (wb_sel),
      .wb_en   (wb_en),
      .flag_z  (flag_z),
      .flag_c  (flag_c)
   );

   function automatic exp_t model(input logic [2:0] o, input logic [15:0] x,
                                  input logic [15:0] y, input logic [3:0] d);
      exp_t        r;
      logic [16:0] s;
      logic [31:0] p;
      logic [3:0]  sh;
      r.sel = d;
      r.c   = 1'b0;
      r.data = 16'h0;
      sh = y[3:0];
      case (o)
         3'd0: begin s = {1'b0, x} + {1'b0, y}; r.data = s[15:0]; r.c = s[16]; end
         3'd1: begin r.data = x - y; r.c = (x < y); end
         3'd2: r.data = x & y;
         3'd3: r.data = x | y;
         3'd4: r.data = x ^ y;
         3'd5: r.data = x << sh;
         3'd6: begin p = {16'h0, x} * {16'h0, y}; r.data = p[15:0]; end
         default: r.data = (y == 16'h0) ? 16'hFFFF : x / y;
      endcase
      r.z = (r.data == 16'h0);
      return r;
   endfunction

   // Scoreboard: every write-back pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && wb_en === 1'b1) begin
         exp_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_wb data=%h sel=%0d t=%0t", wb_data, wb_sel, $time);
         end else begin
            e = sb.pop_front();
            if ({wb_data, wb_sel, flag_z, flag_c} !== {e.data, e.sel, e.z, e.c}) begin
               bad++;
               $display("FAIL wb_result got data=%h sel=%0d z=%b c=%b want data=%h sel=%0d z=%b c=%b",
                        wb_data, wb_sel, flag_z, flag_c, e.data, e.sel, e.z, e.c);
            end
         end
      end
   end

   // Drive one request so that it is sampled at the next rising edge (edge N)
   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [3:0] d, input bit expect_wb);
      @(negedge clk);
      op = o; a = x; b = y; dst_sel = d; start = 1'b1;
      if (expect_wb) sb.push_back(model(o, x, y, d));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Issue, wait (bounded) for the pulse, check latency and return to idle
   task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] d, input int exp_lat, input string name);
      int lat;
      bit got;
      lat = 0;
      got = 1'b0;
      issue(o, x, y, d, 1'b1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (wb_en === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got || lat != exp_lat || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_latency got lat=%0d seen=%0b busy=%b want lat=%0d busy=1",
                  name, lat, got, busy, exp_lat);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || wb_en !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle got busy=%b wb_en=%b want 0 0", name, busy, wb_en);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, wb_en, flag_z, flag_c, wb_data, wb_sel} !== 24'h0) begin
         bad++;
         $display("FAIL reset_state got busy=%b wb_en=%b z=%b c=%b data=%h sel=%0d want all 0",
                  busy, wb_en, flag_z, flag_c, wb_data, wb_sel);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      run_op(3'd0, 16'hFFFF, 16'h0001, 4'd3, 1, "add_wrap");
      run_op(3'd0, 16'h1234, 16'h4321, 4'd2, 1, "add_plain");
   endtask

   task automatic test_sub_shl;
      run_op(3'd1, 16'h0003, 16'h0005, 4'd4, 1, "sub_borrow");
      run_op(3'd5, 16'h0001, 16'h000F, 4'd5, 1, "shl_15");
      run_op(3'd1, 16'h0005, 16'h0005, 4'd6, 1, "sub_zero");
   endtask

   task automatic test_logic;
      for (int i = 2; i <= 4; i++) begin
         run_op(3'(i), 16'hF0A5, 16'h3C3C, 4'(i + 8), 1, "logic");
      end
   endtask

   task automatic test_mul;
      issue(3'd6, 16'h0123, 16'h0010, 4'd7, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 1) begin a = 16'hFFFF; b = 16'hFFFF; dst_sel = 4'd1; end
         total++;
         if (busy !== 1'b1 || wb_en !== (k == 17)) begin
            bad++;
            $display("FAIL mul_timing cycle=%0d got busy=%b wb_en=%b want busy=1 wb_en=%b",
                     k, busy, wb_en, (k == 17));
         end
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL mul_idle got busy=%b want 0", busy);
      end
      run_op(3'd6, 16'hABCD, 16'h1357, 4'd8, 17, "mul_wrap");
   endtask

   task automatic test_div;
      run_op(3'd7, 16'h0064, 16'h0007, 4'd9, 17, "div");
      run_op(3'd7, 16'h1234, 16'h0000, 4'd10, 17, "div_zero");
      run_op(3'd7, 16'hFFFF, 16'h0001, 4'd11, 17, "div_one");
      run_op(3'd7, 16'h0003, 16'h0009, 4'd12, 17, "div_small");
   endtask

   task automatic test_reset_mid_mul;
      int pulses;
      pulses = 0;
      issue(3'd6, 16'h0042, 16'h0042, 4'd2, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || wb_data !== 16'h0 || wb_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_mul got busy=%b data=%h wb_en=%b want 0 0000 0",
                  busy, wb_data, wb_en);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (wb_en === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_abort got pulses=%0d busy=%b want 0 0", pulses, busy);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses = 0;
      // Single-cycle ops: start held high, only every second request lands
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb_en === 1'b1) pulses++;
         op = 3'd0; a = 16'(16'h0111 * (i + 1)); b = 16'h0001; dst_sel = 4'(i); start = 1'b1;
         if (i % 2 == 0) sb.push_back(model(3'd0, a, b, dst_sel));
      end
      @(negedge clk);
      if (wb_en === 1'b1) pulses++;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wb_en === 1'b1) pulses++;
      end
      total++;
      if (pulses != 5) begin
         bad++;
         $display("FAIL b2b_alu_pulses got %0d want 5", pulses);
      end
      // MUL: start held high, one accept per 18 cycles
      pulses = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (wb_en === 1'b1) pulses++;
         op = 3'd6; a = 16'(i + 2); b = 16'h0101; dst_sel = 4'(i % 16); start = 1'b1;
         if (i == 0 || i == 18) sb.push_back(model(3'd6, a, b, dst_sel));
      end
      @(negedge clk);
      if (wb_en === 1'b1) pulses++;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wb_en === 1'b1) pulses++;
      end
      total++;
      if (pulses != 2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_mul_pulses got %0d busy=%b want 2 0", pulses, busy);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_reset_mid_mul();
      test_sub_shl();
      test_logic();
      test_mul();
      test_div();
      test_back_to_back();
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
